muldiv_iter: RTL

Iterative, parametrised multiply/divide unit for the EX stage, replacing the separate multiplier and divider with one shared shift/add datapath. Supports signed and unsigned multiply and divide on WIDTH-bit operands and returns a 2·WIDTH-bit {hi, lo} result. EX raises its stall request while the unit is busy. `annul_i` lets a flush abandon an in-flight operation.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_step.sv | 43 ++++
 rtl/muldiv_iter.sv | 114 +++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Covers op encodings, FSM states and the EX stall levels.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic STALL_STOP    = 1'b1;
    localparam logic STALL_NO_STOP = 1'b0;

    function automatic logic is_div_op(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: add-or-pass then shift right for
// multiply, shift-left trial-subtract (restoring) for divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH:0]   hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH:0]   hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] mul_sel;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        add_sum = hi_i + {1'b0, opnd_i};
        mul_sel = lo_i[0] ? add_sum : hi_i;
        shifted = {hi_i[WIDTH-1:0], lo_i[WIDTH-1]};
        // Bit WIDTH of the difference is the borrow: set means divisor > partial remainder.
        diff    = shifted - {1'b0, opnd_i};
        hi_o    = '0;
        lo_o    = '0;
        if (is_div) begin
            if (!diff[WIDTH]) begin
                hi_o = diff;
                lo_o = {lo_i[WIDTH-2:0], 1'b1};
            end else begin
                hi_o = shifted;
                lo_o = {lo_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_o = {1'b0, mul_sel[WIDTH:1]};
            lo_o = {mul_sel[0], lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned multiply/divide unit for the EX stage.
// One datapath iteration per cycle; result = product or {remainder, quotient}.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic               busy_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               op_div_q;
    logic               sign1_q, sign2_q;
    logic [WIDTH:0]     hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] result_q;

    logic [WIDTH:0]     hi_nxt;
    logic [WIDTH-1:0]   lo_nxt;
    logic               op_signed, op_div, div_zero, start_ok, last_iter;
    logic [WIDTH-1:0]   abs1, abs2;
    logic [WIDTH-1:0]   quo, rem;
    logic [2*WIDTH-1:0] prod, fixed;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (op_div_q),
        .hi_i   (hi_q),
        .lo_i   (lo_q),
        .opnd_i (opnd_q),
        .hi_o   (hi_nxt),
        .lo_o   (lo_nxt)
    );

    always_comb begin
        op_signed = is_signed_op(op_i);
        op_div    = is_div_op(op_i);
        abs1      = (op_signed && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        abs2      = (op_signed && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        div_zero  = op_div && (opdata2_i == '0);
        start_ok  = (state == S_IDLE) && start_i && !annul_i;
        last_iter = (cnt == CNT_W'(WIDTH - 1));

        // Fix-up is taken from the final iteration's output so it lands on the CALC->DONE edge.
        quo   = (sign1_q ^ sign2_q) ? -lo_nxt : lo_nxt;
        rem   = sign1_q ? -hi_nxt[WIDTH-1:0] : hi_nxt[WIDTH-1:0];
        prod  = {hi_nxt[WIDTH-1:0], lo_nxt};
        fixed = op_div_q ? {rem, quo} : ((sign1_q ^ sign2_q) ? -prod : prod);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start_ok) state_nxt = div_zero ? S_DONE : S_CALC;
            S_CALC: begin
                if (annul_i)        state_nxt = S_IDLE;
                else if (last_iter) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            op_div_q <= 1'b0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else if (start_ok) begin
            cnt      <= '0;
            op_div_q <= op_div;
            sign1_q  <= op_signed & opdata1_i[WIDTH-1];
            sign2_q  <= op_signed & opdata2_i[WIDTH-1];
            hi_q     <= '0;
            // Multiply walks the multiplier through lo; divide shifts the dividend out of lo.
            lo_q     <= op_div ? abs1 : abs2;
            opnd_q   <= op_div ? abs2 : abs1;
            if (div_zero) result_q <= {opdata1_i, {WIDTH{1'b1}}};
        end else if (state == S_CALC && !annul_i) begin
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
            cnt  <= cnt + CNT_W'(1);
            if (last_iter) result_q <= fixed;
        end
    end

    assign busy_o   = (state == S_CALC);
    // A flush arriving in the completion cycle suppresses the pulse so EX never consumes it.
    assign ready_o  = (state == S_DONE) && !annul_i;
    assign result_o = result_q;

endmodule
